// File: rtl/m_fetch_queue.sv
// m_fetch_queue: sequential-PC instruction fetch with a DEPTH-entry return FIFO and redirect flush.
module m_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic w_clk,
  input  logic w_rst,
  output logic w_imem_req_valid,
  output logic [31:0] w_imem_req_addr,
  input  logic w_imem_req_ready,
  input  logic w_imem_resp_valid,
  input  logic [31:0] w_imem_resp_data,
  output logic w_inst_valid,
  output logic [31:0] w_inst,
  output logic [31:0] w_inst_pc,
  input  logic w_inst_ready,
  input  logic w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] w_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [31:0] fetch_pc, resp_pc, redir_pc;
  logic [CW-1:0] outstanding, drop, left, drop_next;
  logic [CW:0] credit;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic accept, resp_hit, push, pop;
  assign credit = {1'b0, outstanding} + {1'b0, w_count};
  // gated by reset so nothing is requested while reset is held
  assign w_imem_req_valid = !w_rst && state == RUN && !w_redirect && credit < (CW+1)'(DEPTH);
  assign w_imem_req_addr = fetch_pc;
  assign accept = w_imem_req_valid && w_imem_req_ready;
  assign resp_hit = w_imem_resp_valid && outstanding != '0;
  assign push = state == RUN && !w_redirect && resp_hit;
  assign w_inst_valid = w_count != '0;
  assign pop = w_inst_valid && w_inst_ready && !w_redirect;
  assign w_inst = mem_inst[rd_ptr];
  assign w_inst_pc = mem_pc[rd_ptr];
  assign redir_pc = w_redirect_pc & ~32'h3;
  // responses still in flight after a redirect must be discarded
  assign left = outstanding - CW'(resp_hit);
  assign drop_next = drop - CW'(w_imem_resp_valid && drop != '0);
  always_ff @(posedge w_clk)
    if (push) begin
      mem_inst[wr_ptr] <= w_imem_resp_data;
      mem_pc[wr_ptr] <= resp_pc;
    end
  always_ff @(posedge w_clk or posedge w_rst)
    if (w_rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      w_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (w_redirect) begin
      fetch_pc <= redir_pc;
      resp_pc <= redir_pc;
      w_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      outstanding <= left;
      drop <= left;
      state <= left != '0 ? FLUSH : RUN;
    end else if (state == FLUSH) begin
      drop <= drop_next;
      outstanding <= outstanding - (drop - drop_next);
      state <= drop_next == '0 ? RUN : FLUSH;
    end else begin
      fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc <= push ? resp_pc + 32'd4 : resp_pc;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(push);
      w_count <= w_count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_m_fetch_queue.sv
// tb_m_fetch_queue: directed checks of m_fetch_queue against a variable-latency pipelined imem model.
module tb_m_fetch_queue;
  logic clk, rst;
  logic req_valid, req_ready, resp_valid, inst_valid, inst_ready, redirect;
  logic [31:0] req_addr, resp_data, inst, inst_pc, redirect_pc;
  logic [2:0] count;
  logic [7:0] pv;
  logic [7:0][31:0] pa;
  int lat, n_acc, checks, errors;

  m_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_imem_req_valid(req_valid), .w_imem_req_addr(req_addr), .w_imem_req_ready(req_ready),
    .w_imem_resp_valid(resp_valid), .w_imem_resp_data(resp_data),
    .w_inst_valid(inst_valid), .w_inst(inst), .w_inst_pc(inst_pc), .w_inst_ready(inst_ready),
    .w_redirect(redirect), .w_redirect_pc(redirect_pc), .w_count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // imem: fixed latency lat cycles from accept to response, cleared by the shared reset
  always @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      pa <= '0;
      n_acc <= 0;
    end else begin
      pv <= {pv[6:0], req_valid && req_ready};
      pa <= {pa[6:0], req_addr};
      if (req_valid && req_ready) n_acc <= n_acc + 1;
    end
  assign resp_valid = pv[lat-1];
  assign resp_data = word_at(pa[lat-1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1; lat = l; req_ready = 0; inst_ready = 0; redirect = 0; redirect_pc = 0;
    @(posedge clk);
    #1;
    check("rst_req_valid", 32'(req_valid), 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_count", 32'(count), 0);
    rst = 0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(inst_valid), 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    // sequential stream, 1-cycle imem
    do_reset(1);
    req_ready = 1; inst_ready = 1;
    #1;
    check("t1_req_valid", 32'(req_valid), 1);
    check("t1_addr0", req_addr, 32'h0);
    step();
    check("t1_no_bypass", 32'(inst_valid), 0);
    check("t1_addr4", req_addr, 32'h4);
    step();
    check("t1_first_valid", 32'(inst_valid), 1);
    check("t1_pc0", inst_pc, 32'h0);
    check("t1_inst0", inst, word_at(32'h0));
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t1_pc", inst_pc, 32'(4*k));
      check("t1_inst", inst, word_at(32'(4*k)));
      check("t1_count", 32'(count), 1);
    end
    // credit cap with a stalled consumer
    do_reset(1);
    req_ready = 1;
    repeat (10) step();
    check("t2_accepts", 32'(n_acc), 4);
    check("t2_req_held", 32'(req_valid), 0);
    check("t2_count_full", 32'(count), 4);
    check("t2_head", inst_pc, 32'h0);
    inst_ready = 1;
    step();
    inst_ready = 0;
    check("t2_count_pop", 32'(count), 3);
    check("t2_req_again", 32'(req_valid), 1);
    check("t2_addr16", req_addr, 32'h10);
    repeat (5) step();
    check("t2_one_more", 32'(n_acc), 5);
    check("t2_refull", 32'(count), 4);
    check("t2_head4", inst_pc, 32'h4);
    check("t2_req_held2", 32'(req_valid), 0);
    // redirect with two responses in flight, 3-cycle imem
    do_reset(3);
    req_ready = 1;
    step();
    step();
    req_ready = 0; redirect = 1; redirect_pc = 32'h103;
    #1;
    check("t3_req_gated", 32'(req_valid), 0);
    step();
    redirect = 0; req_ready = 1;
    #1;
    check("t3_flush_count", 32'(count), 0);
    check("t3_flush_req", 32'(req_valid), 0);
    step();
    check("t3_still_flush", 32'(req_valid), 0);
    check("t3_no_stale", 32'(inst_valid), 0);
    step();
    check("t3_resume", 32'(req_valid), 1);
    check("t3_addr", req_addr, 32'h100);
    wait_valid("t3_wait");
    check("t3_pc", inst_pc, 32'h100);
    check("t3_inst", inst, word_at(32'h100));
    // redirect coinciding with a response and a pop, 2-cycle imem
    do_reset(2);
    req_ready = 1; inst_ready = 1;
    step(); step(); step();
    check("t4_pre_pc", inst_pc, 32'h0);
    check("t4_pre_valid", 32'(inst_valid), 1);
    redirect = 1; redirect_pc = 32'h200;
    step();
    redirect = 0;
    #1;
    check("t4_count", 32'(count), 0);
    check("t4_inst_valid", 32'(inst_valid), 0);
    check("t4_flush_req", 32'(req_valid), 0);
    step();
    check("t4_drop1_req", 32'(req_valid), 1);
    check("t4_addr", req_addr, 32'h200);
    wait_valid("t4_wait");
    check("t4_pc", inst_pc, 32'h200);
    // redirect to top of address space, misaligned target
    do_reset(1);
    inst_ready = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    check("t5_req_gated", 32'(req_valid), 0);
    step();
    redirect = 0;
    #1;
    check("t5_req", 32'(req_valid), 1);
    check("t5_addr_top", req_addr, 32'hFFFF_FFFC);
    step();
    check("t5_addr_stable", req_addr, 32'hFFFF_FFFC);
    req_ready = 1;
    step();
    check("t5_addr_wrap", req_addr, 32'h0);
    step();
    check("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    check("t5_inst_top", inst, word_at(32'hFFFF_FFFC));
    check("t5_addr4", req_addr, 32'h4);
    step();
    check("t5_pc_wrap", inst_pc, 32'h0);
    // asynchronous reset with three queued entries
    do_reset(1);
    req_ready = 1;
    step(); step(); step();
    req_ready = 0;
    step();
    check("t6_count3", 32'(count), 3);
    check("t6_req_pre", 32'(req_valid), 1);
    #2 rst = 1;
    #1;
    check("t6_inst_fall", 32'(inst_valid), 0);
    check("t6_req_fall", 32'(req_valid), 0);
    check("t6_count0", 32'(count), 0);
    step();
    rst = 0;
    #1;
    check("t6_restart_req", 32'(req_valid), 1);
    check("t6_restart_addr", req_addr, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
